// File: rtl/mfp_eic_ctrl.sv
// EIC-mode interrupt controller: mask/sense/pending per channel, highest index presented to core.
// Latency: input to EIC_Interrupt is 3 edges for level channels, 2 for edge channels; IAck blanks outputs 1 cycle.
// No backpressure: requests stay pending until acked or cleared; MFP_EIC_EDGE_DETECT_EN enables edge sense.
module mfp_eic_ctrl #(
    parameter int          EIC_CHANNELS    = 32,
    parameter logic [16:0] EIC_BASE_OFFSET = 17'h200
) (
    input  logic                    SI_ClkIn,
    input  logic                    SI_Reset,
    input  logic [EIC_CHANNELS-1:0] EIC_input,
    input  logic                    EIC_IAck,
    input  logic                    reg_we,
    input  logic [1:0]              reg_addr,
    input  logic [31:0]             reg_wdata,
    output logic [31:0]             reg_rdata,
    output logic [7:0]              EIC_Interrupt,
    output logic [5:0]              EIC_Vector,
    output logic [16:0]             EIC_Offset,
    output logic [3:0]              EIC_ShadowSet
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_ACKED
    } state_t;

    localparam logic [31:0] CH_MASK = (EIC_CHANNELS >= 32) ? 32'hFFFF_FFFF
                                                           : ((32'd1 << EIC_CHANNELS) - 32'd1);

    state_t      state;
    logic        ctrl_en;
    logic [31:0] mask_r;
    logic [31:0] sense_r;
    logic [31:0] pend_r;
    logic [31:0] pend_nxt;
    logic [31:0] in_ext;
    logic [31:0] in_q;
    logic [31:0] elig;
    logic [4:0]  enc_idx;
    logic        enc_vld;

    assign EIC_ShadowSet = 4'd0;

    // Non-existent channels are tied low so nothing above EIC_CHANNELS can pend.
    always_comb begin
        in_ext = '0;
        in_ext[EIC_CHANNELS-1:0] = EIC_input;
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            ctrl_en <= 1'b0;
            mask_r  <= '0;
            in_q    <= '0;
        end else begin
            in_q <= in_ext;
            if (reg_we && reg_addr == 2'd0)
                ctrl_en <= reg_wdata[0];
            if (reg_we && reg_addr == 2'd1)
                mask_r <= reg_wdata & CH_MASK;
        end
    end

`ifdef MFP_EIC_EDGE_DETECT_EN
    logic [31:0] edge_v;
    logic [31:0] clr_v;

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset)
            sense_r <= '0;
        else if (reg_we && reg_addr == 2'd2)
            sense_r <= reg_wdata & CH_MASK;
    end

    // A fresh edge in the same cycle as a W1C or ack keeps the bit set.
    always_comb begin
        edge_v = in_ext & ~in_q;
        clr_v  = '0;
        if (reg_we && reg_addr == 2'd3)
            clr_v = clr_v | reg_wdata;
        if (state == ST_PRESENT && EIC_IAck)
            clr_v = clr_v | (32'd1 << EIC_Vector[4:0]);
        pend_nxt = (sense_r & (edge_v | (pend_r & ~clr_v))) | (~sense_r & in_q);
    end
`else
    assign sense_r = '0;

    always_comb begin
        pend_nxt = in_q;
    end
`endif

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset)
            pend_r <= '0;
        else
            pend_r <= pend_nxt & CH_MASK;
    end

    assign elig = ctrl_en ? (pend_r & mask_r) : '0;

    always_comb begin
        enc_idx = '0;
        enc_vld = |elig;
        for (int i = 0; i < 32; i++) begin
            if (elig[i])
                enc_idx = 5'(i);
        end
    end

    always_comb begin
        case (reg_addr)
            2'd0:    reg_rdata = {31'd0, ctrl_en};
            2'd1:    reg_rdata = mask_r;
            2'd2:    reg_rdata = sense_r;
            default: reg_rdata = pend_r;
        endcase
    end

    // ACKED holds outputs at zero for one cycle, then re-evaluates like IDLE.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            state         <= ST_IDLE;
            EIC_Interrupt <= '0;
            EIC_Vector    <= '0;
            EIC_Offset    <= '0;
        end else begin
            case (state)
                ST_PRESENT: begin
                    if (EIC_IAck) begin
                        state         <= ST_ACKED;
                        EIC_Interrupt <= '0;
                        EIC_Vector    <= '0;
                        EIC_Offset    <= '0;
                    end else if (!enc_vld) begin
                        state         <= ST_IDLE;
                        EIC_Interrupt <= '0;
                        EIC_Vector    <= '0;
                        EIC_Offset    <= '0;
                    end else begin
                        state         <= ST_PRESENT;
                        EIC_Interrupt <= {3'd0, enc_idx} + 8'd1;
                        EIC_Vector    <= {1'b0, enc_idx};
                        EIC_Offset    <= EIC_BASE_OFFSET + {7'd0, enc_idx, 5'd0};
                    end
                end
                ST_IDLE, ST_ACKED: begin
                    if (enc_vld) begin
                        state         <= ST_PRESENT;
                        EIC_Interrupt <= {3'd0, enc_idx} + 8'd1;
                        EIC_Vector    <= {1'b0, enc_idx};
                        EIC_Offset    <= EIC_BASE_OFFSET + {7'd0, enc_idx, 5'd0};
                    end else begin
                        state         <= ST_IDLE;
                        EIC_Interrupt <= '0;
                        EIC_Vector    <= '0;
                        EIC_Offset    <= '0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    EIC_Interrupt <= '0;
                    EIC_Vector    <= '0;
                    EIC_Offset    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_eic_ctrl.sv
// Scoreboard bench for mfp_eic_ctrl with 8 channels; edge-sense cases run when MFP_EIC_EDGE_DETECT_EN is set.
module tb_mfp_eic_ctrl;

    logic        SI_ClkIn = 1'b0;
    logic        SI_Reset;
    logic [7:0]  EIC_input;
    logic        EIC_IAck;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [7:0]  EIC_Interrupt;
    logic [5:0]  EIC_Vector;
    logic [16:0] EIC_Offset;
    logic [3:0]  EIC_ShadowSet;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [7:0]  irq;
        logic [5:0]  vec;
        logic [16:0] off;
    } exp_t;

    exp_t exp_q[$];

    mfp_eic_ctrl #(
        .EIC_CHANNELS    (8),
        .EIC_BASE_OFFSET (17'h200)
    ) dut (
        .SI_ClkIn      (SI_ClkIn),
        .SI_Reset      (SI_Reset),
        .EIC_input     (EIC_input),
        .EIC_IAck      (EIC_IAck),
        .reg_we        (reg_we),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_rdata     (reg_rdata),
        .EIC_Interrupt (EIC_Interrupt),
        .EIC_Vector    (EIC_Vector),
        .EIC_Offset    (EIC_Offset),
        .EIC_ShadowSet (EIC_ShadowSet)
    );

    always #5 SI_ClkIn = ~SI_ClkIn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ch < 0 means no request should be presented.
    task automatic push_exp(input string tag, input int ch);
        exp_t e;
        e.tag = tag;
        if (ch < 0) begin
            e.irq = 8'd0;
            e.vec = 6'd0;
            e.off = 17'd0;
        end else begin
            e.irq = 8'(ch + 1);
            e.vec = 6'(ch);
            e.off = 17'(32'h200 + ch * 32'h20);
        end
        exp_q.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, ".irq"}, 32'(EIC_Interrupt), 32'(e.irq));
        chk({e.tag, ".vec"}, 32'(EIC_Vector), 32'(e.vec));
        chk({e.tag, ".off"}, 32'(EIC_Offset), 32'(e.off));
        chk({e.tag, ".shadow"}, 32'(EIC_ShadowSet), 32'd0);
    endtask

    task automatic tick();
        @(posedge SI_ClkIn);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic reg_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        reg_addr = a;
        #1;
        chk(tag, reg_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        SI_Reset  = 1'b1;
        EIC_input = '0;
        EIC_IAck  = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        tick();
        tick();
        SI_Reset = 1'b0;

        push_exp("reset", -1);
        pop_chk();
        reg_chk("rst_ctrl", 2'd0, 32'd0);
        reg_chk("rst_mask", 2'd1, 32'd0);
        reg_chk("rst_sense", 2'd2, 32'd0);
        reg_chk("rst_pend", 2'd3, 32'd0);

        reg_wr(2'd0, 32'd1);
        reg_wr(2'd1, 32'hFFFF_FFFF);
        reg_chk("mask_upper", 2'd1, 32'h0000_00FF);
        reg_wr(2'd2, 32'd0);

        // Level channel 6: nothing after two edges, presented after the third.
        EIC_input[6] = 1'b1;
        push_exp("lat_early", -1);
        tick();
        tick();
        pop_chk();
        push_exp("lvl6", 6);
        tick();
        pop_chk();
        EIC_input[6] = 1'b0;
        push_exp("lvl6_drop", -1);
        repeat (3) tick();
        pop_chk();

`ifdef MFP_EIC_EDGE_DETECT_EN
        reg_wr(2'd2, 32'h20);
        reg_chk("sense_rd", 2'd2, 32'h20);
        EIC_input[5] = 1'b1;
        tick();
        EIC_input[5] = 1'b0;
        push_exp("edge5_held", 5);
        repeat (3) tick();
        pop_chk();
        EIC_IAck = 1'b1;
        push_exp("edge5_ack", -1);
        tick();
        EIC_IAck = 1'b0;
        pop_chk();
        push_exp("edge5_stay0", -1);
        tick();
        tick();
        pop_chk();
        reg_chk("edge5_pend", 2'd3, 32'd0);
`else
        reg_wr(2'd2, 32'hFF);
        reg_chk("sense_absent", 2'd2, 32'd0);
`endif

        // Channels 1 and 7 both pending: 7 wins until masked.
        EIC_input = 8'h82;
        push_exp("ch1_7", 7);
        repeat (3) tick();
        pop_chk();
        reg_wr(2'd1, 32'h7F);
        push_exp("mask_wr_edge", 7);
        pop_chk();
        push_exp("mask7", 1);
        tick();
        pop_chk();

        reg_wr(2'd1, 32'hFF);
        push_exp("unmask7", 7);
        tick();
        pop_chk();
        EIC_IAck = 1'b1;
        push_exp("lvl7_ack", -1);
        tick();
        EIC_IAck = 1'b0;
        pop_chk();
        push_exp("lvl7_reassert", 7);
        tick();
        pop_chk();
        reg_wr(2'd0, 32'd0);
        push_exp("ctrl_off", -1);
        tick();
        pop_chk();

`ifdef MFP_EIC_EDGE_DETECT_EN
        EIC_input = '0;
        repeat (3) tick();
        EIC_input[5] = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = 2'd3;
        reg_wdata = 32'h20;
        tick();
        reg_we = 1'b0;
        EIC_input[5] = 1'b0;
        reg_chk("set_wins", 2'd3, 32'h20);
        tick();
        EIC_IAck = 1'b1;
        tick();
        EIC_IAck = 1'b0;
        reg_chk("ack_idle_ignored", 2'd3, 32'h20);
        reg_wr(2'd3, 32'h20);
        reg_chk("w1c", 2'd3, 32'd0);
`endif

        // Reset while channel 7 is presented.
        EIC_input = 8'h80;
        reg_wr(2'd0, 32'd1);
        repeat (3) tick();
        push_exp("pre_rst", 7);
        pop_chk();
        SI_Reset = 1'b1;
        push_exp("rst_mid", -1);
        tick();
        SI_Reset = 1'b0;
        pop_chk();
        reg_chk("rst_mid_ctrl", 2'd0, 32'd0);
        reg_chk("rst_mid_mask", 2'd1, 32'd0);
        reg_chk("rst_mid_pend", 2'd3, 32'd0);
        push_exp("post_rst", -1);
        tick();
        tick();
        pop_chk();

        if (exp_q.size() != 0)
            chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
